// File: rtl/odata_req_pkg.sv
// Shared types for the read-request splitter: FSM states, the pool command word
// and the beat-size shift helper.
package odata_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } split_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] size;
  } cmd_word_t;

  // Byte-to-beat shift amount for a power-of-2 beat width
  function automatic int beat_shift(input int beat_bytes);
    return $clog2(beat_bytes);
  endfunction

endpackage

// File: rtl/odata_burst_chunk_calc.sv
// Combinational burst sizer: beats for the next command, limited by the remaining
// beats, MAX_BURST and the distance to the next BOUNDARY page.
module odata_burst_chunk_calc
  import odata_req_pkg::*;
#(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BURST  = 256,
  parameter int BOUNDARY   = 4096
) (
  input  logic [31:0] cur_addr_i,
  input  logic [31:0] remain_i,
  output logic [31:0] chunk_o
);

  localparam int          SHIFT   = beat_shift(BEAT_BYTES);
  localparam logic [32:0] BOUND33 = 33'(BOUNDARY);
  localparam logic [31:0] MAXB32  = 32'(MAX_BURST);

  logic [32:0] offs_s;
  logic [32:0] page_bytes_s;
  logic [31:0] page_left_s;
  logic [31:0] cap_s;

  // 33-bit page math so a full 2^32 boundary would still work
  always_comb begin
    offs_s       = {1'b0, cur_addr_i} & (BOUND33 - 33'd1);
    page_bytes_s = BOUND33 - offs_s;
    page_left_s  = 32'(page_bytes_s >> SHIFT);
    if (page_left_s < MAXB32) begin
      cap_s = page_left_s;
    end else begin
      cap_s = MAXB32;
    end
    if (remain_i < cap_s) begin
      chunk_o = remain_i;
    end else begin
      chunk_o = cap_s;
    end
  end

endmodule

// File: rtl/odata_req_splitter.sv
// Splits one large read request into AXI4-legal burst commands for the data pool.
// Optional statistics counters are enabled with ODATA_REQ_SPLITTER_STAT_EN.
module odata_req_splitter
  import odata_req_pkg::*;
#(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BURST  = 256,
  parameter int BOUNDARY   = 4096,
  parameter int EXSIZE     = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_beats,
  input  logic [EXSIZE-1:0] req_ex,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [63:0]       cmd_data,
  output logic [EXSIZE-1:0] cmd_ex,
  output logic              cmd_first,
  output logic              cmd_last,
  output logic              busy
`ifdef ODATA_REQ_SPLITTER_STAT_EN
  ,
  output logic [31:0]       stat_req_cnt,
  output logic [31:0]       stat_cmd_cnt
`endif
);

  localparam int          SHIFT     = beat_shift(BEAT_BYTES);
  localparam logic [31:0] ADDR_MASK = ~(32'(BEAT_BYTES) - 32'd1);

  split_state_e      state_q, state_d;
  logic [31:0]       cur_addr_q, cur_addr_d;
  logic [31:0]       remain_q, remain_d;
  logic [EXSIZE-1:0] ex_q, ex_d;
  logic              first_q, first_d;
  logic [31:0]       chunk_q, chunk_d;
  cmd_word_t         cmd_word_q, cmd_word_d;
  logic [EXSIZE-1:0] cmd_ex_q, cmd_ex_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_first_q, cmd_first_d;
  logic              cmd_last_q, cmd_last_d;
  logic              busy_q, busy_d;
  logic [31:0]       chunk_s;
  logic              req_hs_s;
  logic              cmd_hs_s;

  odata_burst_chunk_calc #(
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BURST  (MAX_BURST),
    .BOUNDARY   (BOUNDARY)
  ) u_chunk_calc (
    .cur_addr_i (cur_addr_q),
    .remain_i   (remain_q),
    .chunk_o    (chunk_s)
  );

  assign req_ready = (state_q == IDLE);
  assign req_hs_s  = req_valid && req_ready;
  assign cmd_hs_s  = cmd_valid_q && cmd_ready;

  // Next-state and next-output logic; everything holds unless a state acts on it
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remain_d    = remain_q;
    ex_d        = ex_q;
    first_d     = first_q;
    chunk_d     = chunk_q;
    cmd_word_d  = cmd_word_q;
    cmd_ex_d    = cmd_ex_q;
    cmd_valid_d = cmd_valid_q;
    cmd_first_d = cmd_first_q;
    cmd_last_d  = cmd_last_q;
    case (state_q)
      IDLE: begin
        if (req_hs_s) begin
          cur_addr_d = req_addr & ADDR_MASK;
          remain_d   = req_beats;
          ex_d       = req_ex;
          first_d    = 1'b1;
          state_d    = (req_beats == 32'd0) ? IDLE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        chunk_d         = chunk_s;
        cmd_word_d.addr = cur_addr_q;
        cmd_word_d.size = chunk_s - 32'd1;
        cmd_ex_d        = ex_q;
        cmd_first_d     = first_q;
        cmd_last_d      = (chunk_s == remain_q);
        cmd_valid_d     = 1'b1;
        state_d         = EMIT;
      end
      EMIT: begin
        if (cmd_hs_s) begin
          cmd_valid_d = 1'b0;
          cur_addr_d  = cur_addr_q + (chunk_q << SHIFT);
          remain_d    = remain_q - chunk_q;
          first_d     = 1'b0;
          state_d     = (remain_q == chunk_q) ? IDLE : CALC;
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= 32'd0;
      remain_q    <= 32'd0;
      ex_q        <= '0;
      first_q     <= 1'b0;
      chunk_q     <= 32'd0;
      cmd_word_q  <= '0;
      cmd_ex_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_first_q <= 1'b0;
      cmd_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      ex_q        <= ex_d;
      first_q     <= first_d;
      chunk_q     <= chunk_d;
      cmd_word_q  <= cmd_word_d;
      cmd_ex_q    <= cmd_ex_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_first_q <= cmd_first_d;
      cmd_last_q  <= cmd_last_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_word_q;
  assign cmd_ex    = cmd_ex_q;
  assign cmd_first = cmd_first_q;
  assign cmd_last  = cmd_last_q;
  assign busy      = busy_q;

`ifdef ODATA_REQ_SPLITTER_STAT_EN
  logic [31:0] stat_req_q, stat_req_d;
  logic [31:0] stat_cmd_q, stat_cmd_d;

  // Handshake counters, wrapping naturally at 2^32
  always_comb begin
    stat_req_d = stat_req_q;
    stat_cmd_d = stat_cmd_q;
    if (req_hs_s) begin
      stat_req_d = stat_req_q + 32'd1;
    end else begin
      stat_req_d = stat_req_q;
    end
    if (cmd_hs_s) begin
      stat_cmd_d = stat_cmd_q + 32'd1;
    end else begin
      stat_cmd_d = stat_cmd_q;
    end
  end

  // Counter registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stat_req_q <= 32'd0;
      stat_cmd_q <= 32'd0;
    end else begin
      stat_req_q <= stat_req_d;
      stat_cmd_q <= stat_cmd_d;
    end
  end

  assign stat_req_cnt = stat_req_q;
  assign stat_cmd_cnt = stat_cmd_q;
`endif

endmodule

// File: tb/tb_odata_req_splitter.sv
// Scoreboard bench for odata_req_splitter: expected commands are queued when a
// request is driven and compared on every cmd handshake.
module tb_odata_req_splitter;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] ex;
    logic        first;
    logic        last;
  } exp_cmd_t;

  logic        clock;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_beats;
  logic [31:0] req_ex;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_data;
  logic [31:0] cmd_ex;
  logic        cmd_first;
  logic        cmd_last;
  logic        busy;
`ifdef ODATA_REQ_SPLITTER_STAT_EN
  logic [31:0] stat_req_cnt;
  logic [31:0] stat_cmd_cnt;
`endif

  exp_cmd_t sb_q[$];
  int       n_tests;
  int       n_fail;
  int       n_pop;

  odata_req_splitter dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_beats (req_beats),
    .req_ex    (req_ex),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_ex    (cmd_ex),
    .cmd_first (cmd_first),
    .cmd_last  (cmd_last),
    .busy      (busy)
`ifdef ODATA_REQ_SPLITTER_STAT_EN
    ,
    .stat_req_cnt (stat_req_cnt),
    .stat_cmd_cnt (stat_cmd_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] sz, input logic [31:0] ex,
                      input logic f, input logic l);
    exp_cmd_t e;
    e.data  = {a, sz};
    e.ex    = ex;
    e.first = f;
    e.last  = l;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor on the falling edge
  always @(negedge clock) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_cmd", {32'd0, cmd_data[63:32]}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_cmd_t e;
        e = sb_q.pop_front();
        chk("cmd_data", cmd_data, e.data);
        chk("cmd_ex", {32'd0, cmd_ex}, {32'd0, e.ex});
        chk("cmd_first", {63'd0, cmd_first}, {63'd0, e.first});
        chk("cmd_last", {63'd0, cmd_last}, {63'd0, e.last});
      end
      n_pop++;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ex);
    logic got;
    got = 1'b0;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_beats = b;
    req_ex    = ex;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clock);
      if (req_ready) got = 1'b1;
    end
    if (!got) chk("req_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clock);
      if (sb_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) chk(tag, {32'd0, 32'(sb_q.size())}, 64'd0);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_rdy"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_vld"}, {63'd0, cmd_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_data"}, cmd_data, 64'd0);
    chk({tag, "_ex"}, {32'd0, cmd_ex}, 64'd0);
    chk({tag, "_fl"}, {62'd0, cmd_first, cmd_last}, 64'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_pop     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    req_beats = 32'd0;
    req_ex    = 32'd0;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset_outputs("rst");
    rst_n = 1'b1;

    // Zero length request
    send(32'h0000_2000, 32'd0, 32'h0000_0ABC);
    @(negedge clock);
    chk("zero_rdy", {63'd0, req_ready}, 64'd1);
    chk("zero_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("zero_vld", {63'd0, cmd_valid}, 64'd0);
    end
`ifdef ODATA_REQ_SPLITTER_STAT_EN
    chk("zero_stat_req", {32'd0, stat_req_cnt}, 64'd1);
    chk("zero_stat_cmd", {32'd0, stat_cmd_cnt}, 64'd0);
`endif

    // Large split with latency check
    push(32'h0000_1000, 32'd255, 32'hCAFE_0001, 1'b1, 1'b0);
    push(32'h0000_1800, 32'd255, 32'hCAFE_0001, 1'b0, 1'b0);
    push(32'h0000_2000, 32'd87,  32'hCAFE_0001, 1'b0, 1'b1);
    send(32'h0000_1000, 32'd600, 32'hCAFE_0001);
    @(negedge clock);
    chk("lat_n1", {63'd0, cmd_valid}, 64'd0);
    chk("rdy_busy", {63'd0, req_ready}, 64'd0);
    @(negedge clock);
    chk("lat_n2", {63'd0, cmd_valid}, 64'd1);
    drain("large_drain");

    // Page crossing, with low address bits that must be ignored
    push(32'h0000_0FF0, 32'd1, 32'h0000_0022, 1'b1, 1'b0);
    push(32'h0000_1000, 32'd7, 32'h0000_0022, 1'b0, 1'b1);
    send(32'h0000_0FF5, 32'd10, 32'h0000_0022);
    drain("page_drain");

    // Backpressure
    cmd_ready = 1'b0;
    push(32'h0000_0000, 32'd3, 32'h0000_0033, 1'b1, 1'b1);
    send(32'h0000_0000, 32'd4, 32'h0000_0033);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_vld", {63'd0, cmd_valid}, 64'd1);
      chk("bp_data", cmd_data, {32'h0, 32'd3});
    end
    @(posedge clock);
    #1;
    cmd_ready = 1'b1;
    @(negedge clock);
    chk("bp_busy_hs", {63'd0, busy}, 64'd1);
    @(negedge clock);
    chk("bp_busy_fall", {63'd0, busy}, 64'd0);
    chk("bp_vld_fall", {63'd0, cmd_valid}, 64'd0);
    drain("bp_drain");

    // Address wrap
    push(32'hFFFF_FFF8, 32'd0, 32'h0000_0044, 1'b1, 1'b0);
    push(32'h0000_0000, 32'd0, 32'h0000_0044, 1'b0, 1'b1);
    send(32'hFFFF_FFF8, 32'd2, 32'h0000_0044);
    drain("wrap_drain");
`ifdef ODATA_REQ_SPLITTER_STAT_EN
    chk("stat_req", {32'd0, stat_req_cnt}, 64'd5);
    chk("stat_cmd", {32'd0, stat_cmd_cnt}, 64'd8);
`endif

    // Reset during the second command of the large split
    begin
      int base;
      logic seen;
      base = n_pop;
      seen = 1'b0;
      push(32'h0000_1000, 32'd255, 32'hCAFE_0002, 1'b1, 1'b0);
      send(32'h0000_1000, 32'd600, 32'hCAFE_0002);
      for (int i = 0; i < 50 && n_pop == base; i++) @(posedge clock);
      #1;
      cmd_ready = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clock);
        if (cmd_valid) seen = 1'b1;
      end
      chk("rst2_seen", {63'd0, seen}, 64'd1);
      chk("rst2_data", cmd_data, {32'h0000_1800, 32'd255});
      rst_n = 1'b0;
      #1;
      reset_outputs("midrst");
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      cmd_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        chk("midrst_quiet", {63'd0, cmd_valid}, 64'd0);
      end
    end
    push(32'h0000_0FF0, 32'd1, 32'h0000_0055, 1'b1, 1'b0);
    push(32'h0000_1000, 32'd7, 32'h0000_0055, 1'b0, 1'b1);
    send(32'h0000_0FF0, 32'd10, 32'h0000_0055);
    drain("post_rst_drain");

    chk("sb_empty", {32'd0, 32'(sb_q.size())}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
